// File: rtl/light_reader.sv
// light_reader: deserialises start-bit framed light-chain bits into WIDTH-bit frames
// with a one-deep output holding register. Define LIGHT_READER_COUNT_EN to add cnt.
module light_reader #(
    parameter int WIDTH = 8
) (
    input  logic             arst,
    input  logic             clk,
    input  logic             step,
    input  logic             sin,
    input  logic             clr,
    input  logic             dready,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             busy,
    output logic             ovf
`ifdef LIGHT_READER_COUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] cnt
`endif
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic [0:0]       state_reg,  state_next;
    logic [BW-1:0]    bitcnt_reg, bitcnt_next;
    // Only WIDTH-1 bits are stored: the newest bit enters the frame straight from sin.
    logic [WIDTH-2:0] shreg_reg,  shreg_next;
    logic [WIDTH-1:0] dout_reg,   dout_next;
    logic             dvalid_reg, dvalid_next;
    logic             ovf_reg,    ovf_next;

    logic [WIDTH-1:0] frame;
    logic             shift_en;
    logic             complete;
    logic             accept;
    logic             overrun;

    assign frame    = {shreg_reg, sin};
    assign shift_en = (state_reg == SHIFT) && step;
    assign complete = shift_en && (bitcnt_reg == LAST_BIT);
    assign accept   = complete && (!dvalid_reg || dready);
    assign overrun  = complete && dvalid_reg && !dready;

    always_comb begin
        state_next  = state_reg;
        bitcnt_next = bitcnt_reg;
        shreg_next  = shreg_reg;
        case (state_reg)
            IDLE: begin
                if (step && sin) begin
                    state_next  = SHIFT;
                    bitcnt_next = '0;
                end
            end
            SHIFT: begin
                if (step) begin
                    shreg_next = frame[WIDTH-2:0];
                    if (complete) begin
                        state_next  = IDLE;
                        bitcnt_next = '0;
                    end else begin
                        bitcnt_next = bitcnt_reg + BW'(1);
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                bitcnt_next = '0;
            end
        endcase
    end

    always_comb begin
        dout_next   = dout_reg;
        dvalid_next = dvalid_reg;
        if (accept) begin
            dout_next   = frame;
            dvalid_next = 1'b1;
        end else if (dvalid_reg && dready) begin
            dvalid_next = 1'b0;
        end
    end

    // A fresh overrun beats a simultaneous clear.
    always_comb begin
        ovf_next = ovf_reg;
        if (overrun) begin
            ovf_next = 1'b1;
        end else if (clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg  <= IDLE;
            bitcnt_reg <= '0;
            shreg_reg  <= '0;
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bitcnt_reg <= bitcnt_next;
            shreg_reg  <= shreg_next;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign dout   = dout_reg;
    assign dvalid = dvalid_reg;
    assign busy   = (state_reg == SHIFT);
    assign ovf    = ovf_reg;

`ifdef LIGHT_READER_COUNT_EN
    logic [CW-1:0] ones_acc [0:WIDTH];
    logic [CW-1:0] cnt_reg, cnt_next;

    assign ones_acc[0] = '0;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_popcount
            assign ones_acc[gi+1] = ones_acc[gi] + {{(CW-1){1'b0}}, frame[gi]};
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        if (accept) begin
            cnt_next = ones_acc[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_light_reader.sv
// Bench for light_reader (WIDTH=8): directed frames plus random traffic, scoreboarded
// against a frame-level model. Works with or without LIGHT_READER_COUNT_EN.
module tb_light_reader;
    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       step = 1'b0;
    logic       sin = 1'b0;
    logic       clr = 1'b0;
    logic       dready = 1'b0;
    logic [7:0] dout;
    logic       dvalid;
    logic       busy;
    logic       ovf;
`ifdef LIGHT_READER_COUNT_EN
    logic [3:0] cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Frame-level reference model
    logic       m_busy = 1'b0;
    bit         m_bits[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;

    light_reader #(.WIDTH(8)) dut (
        .arst   (arst),
        .clk    (clk),
        .step   (step),
        .sin    (sin),
        .clr    (clr),
        .dready (dready),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy),
        .ovf    (ovf)
`ifdef LIGHT_READER_COUNT_EN
        ,
        .cnt    (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        step = 1'b0; sin = 1'b0; dready = 1'b0; clr = 1'b0;
        arst = 1'b1;
        m_busy = 1'b0; m_bits.delete(); m_valid = 1'b0; m_dout = 8'h00; m_ovf = 1'b0;
        sb.delete();
        #2;
        check("rst_dout", dout, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
`ifdef LIGHT_READER_COUNT_EN
        check("rst_cnt", cnt, 0);
`endif
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    // Drive one clock of inputs, then advance the model by what those inputs mean.
    task automatic cycle(input logic s, input logic b, input logic r, input logic c);
        logic [7:0] fr;
        logic done;
        logic ov;
        step = s; sin = b; dready = r; clr = c;
        @(posedge clk); #1;
        done = 1'b0;
        fr = 8'h00;
        if (s) begin
            if (!m_busy) begin
                if (b) begin
                    m_busy = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == 8) begin
                    foreach (m_bits[i]) if (m_bits[i]) fr[7-i] = 1'b1;
                    m_busy = 1'b0;
                    done = 1'b1;
                end
            end
        end
        ov = done && m_valid && !r;
        if (done && !ov) begin
            m_valid = 1'b1;
            m_dout = fr;
            sb.push_back(fr);
        end else if (!done && m_valid && r) begin
            m_valid = 1'b0;
        end
        if (ov) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input int gap, input logic rdy_last);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0);
                check("gap_busy", busy, 1);
            end
            cycle(1'b1, v[7-i], (i == 7) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    // Monitor: status against the model every cycle; data on each consumer handshake.
    always @(negedge clk) begin
        if (!arst) begin
            check("mon_dvalid", dvalid, m_valid);
            check("mon_busy", busy, m_busy);
            check("mon_ovf", ovf, m_ovf);
            if (dvalid && dready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got frame %0h expected none", dout);
                end else begin
                    mon_exp = sb.pop_front();
                    check("mon_dout", dout, mon_exp);
`ifdef LIGHT_READER_COUNT_EN
                    check("mon_cnt", cnt, $countones(mon_exp));
`endif
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        repeat (5) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check("idle_busy", busy, 0);
            check("idle_dvalid", dvalid, 0);
        end

        send_frame(8'hB2, 0, 1'b0);
        check("b2_dout", dout, 8'hB2);
        check("b2_dvalid", dvalid, 1);
        check("b2_ovf", ovf, 0);
`ifdef LIGHT_READER_COUNT_EN
        check("b2_cnt", cnt, 4);
`endif

        send_frame(8'h0F, 0, 1'b0);
        check("ovr_dout", dout, 8'hB2);
        check("ovr_ovf", ovf, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", ovf, 0);

        send_frame(8'h55, 0, 1'b1);
        check("swap_dout", dout, 8'h55);
        check("swap_dvalid", dvalid, 1);
        check("swap_ovf", ovf, 0);

        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_frame(8'hFF, 0, 1'b0);
        check("abort_dout", dout, 8'hFF);
        check("abort_dvalid", dvalid, 1);
`ifdef LIGHT_READER_COUNT_EN
        check("abort_cnt", cnt, 8);
`endif

        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 3, 1'b0);
        check("gap_dout", dout, 8'hA5);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/light_reader.md
LIGHT_READER -- requirements
Module: light_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per light frame (legal 2..16).
REQ-002 SHALL have port arst  input  1  asynchronous reset, active-high.
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have port step  input  1  one-cycle strobe marking a light-chain shift; sin is sampled only when step=1.
REQ-005 SHALL have port sin  input  1  serial light bit from the tail of the light chain.
REQ-006 SHALL have port clr  input  1  synchronous clear of ovf.
REQ-007 SHALL have port dready  input  1  consumer accepts dout.
REQ-008 SHALL have port dout  output  WIDTH  last complete frame, MSB = first received data bit.
REQ-009 SHALL have port dvalid  output  1  dout holds an unconsumed frame.
REQ-010 SHALL have port busy  output  1  frame reception in progress (state SHIFT).
REQ-011 SHALL have port ovf  output  1  sticky overrun flag.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT; frame = one start bit (sin=1), then WIDTH data bits.
REQ-013 IDLE: step&sin=1 -> SHIFT, bit counter=0; step&sin=0 -> stay IDLE; no step -> no change.
REQ-014 SHIFT: on each step, shift register <= {shreg[WIDTH-2:0], sin} and bit counter increments.
REQ-015 SHIFT: on the step sampling data bit WIDTH-1 -> IDLE and frame completes; cycles without step hold all state.
REQ-016 On completion with dvalid=0, or dvalid=1 & dready=1 in the same cycle: dout <= assembled frame, dvalid=1 on the next clock edge (latency 1 cycle after final step).
REQ-017 On completion with dvalid=1 & dready=0: frame dropped, dout unchanged, ovf <= 1.
REQ-018 dvalid=1 & dready=1 with no completion: dvalid <= 0 next edge; dout holds its value.
REQ-019 ovf stays 1 until clr=1; clr and a new overrun in the same cycle -> ovf=1 (set wins).
REQ-020 Bit counter SHALL be $clog2(WIDTH) bits wide and never wrap mid-frame.
REQ-021 busy SHALL equal 1 exactly while in SHIFT.

Reset
REQ-022 arst=1 SHALL immediately force IDLE, shreg=0, bit counter=0, dout=0, dvalid=0, busy=0, ovf=0, cnt=0 (if present).
REQ-023 arst asserted mid-frame SHALL abort the frame; no partial frame is ever presented.

Configuration
REQ-024 Macro LIGHT_READER_COUNT_EN defined: adds output cnt  $clog2(WIDTH+1) bits = number of 1s in dout, registered together with dout (same edge).
REQ-025 Macro LIGHT_READER_COUNT_EN undefined: port cnt and its logic absent; all other behaviour identical.

Verification
REQ-026 Reset, then step with sin=1, then 8 steps sin=1,0,1,1,0,0,1,0, dready=0 -> dout=8'hB2, dvalid=1 one cycle after 8th data step, ovf=0, cnt=4 if COUNT_EN.
REQ-027 Steps with sin=0 in IDLE (5 steps) -> busy stays 0, dvalid stays 0.
REQ-028 dvalid=1, dready=0, second full frame 8'h0F received -> dout stays 8'hB2, ovf=1; clr=1 one cycle -> ovf=0.
REQ-029 dvalid=1 with dready=1 on the exact completion cycle of frame 8'h55 -> dout=8'h55, dvalid stays 1, ovf=0.
REQ-030 arst pulsed after 4 data bits, then full frame 8'hFF -> dout=8'hFF, no trace of aborted bits, cnt=8 if COUNT_EN.
REQ-031 Gaps of 3 idle cycles between steps during frame 8'hA5 -> dout=8'hA5, busy=1 throughout the gaps.
